// File: rtl/led_mode_ctrl_if.sv
// Bundle of the button input and LED-control outputs of led_mode_ctrl.
// The master side drives the raw button and observes the controls; the
// slave side is the controller itself.
interface led_mode_ctrl_if;
    logic       btn_n;        // raw push-button, active-low, asynchronous
    logic       tick;         // one-cycle clock enable for the pattern stage
    logic [1:0] mode;         // LED pair select
    logic       running;      // high while ticks are generated
    logic       press_pulse;  // one-cycle pulse per accepted short press

    modport master (
        output btn_n,
        input  tick,
        input  mode,
        input  running,
        input  press_pulse
    );

    modport slave (
        input  btn_n,
        output tick,
        output mode,
        output running,
        output press_pulse
    );
endinterface

// File: rtl/led_mode_ctrl.sv
// LED mode controller: debounces one push-button, steps the LED pair
// select on each short press, toggles tick generation on each long press,
// and produces the periodic tick enable for the downstream pattern stage.
module led_mode_ctrl #(
    parameter int DEBOUNCE_CYC = 250000,   // stable cycles to accept press/release
    parameter int TICK_CYC     = 12500000, // cycles per tick period
    parameter int LONG_CYC     = 25000000  // debounced hold cycles for a long press
) (
    input  logic           clk,
    input  logic           nRst,
    led_mode_ctrl_if.slave bus
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int HOLD_W = $clog2(LONG_CYC + 1);
    localparam int TICK_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

    localparam logic [DB_W-1:0]   DB_END    = DB_W'(DEBOUNCE_CYC);
    localparam logic [HOLD_W-1:0] HOLD_END  = HOLD_W'(LONG_CYC);
    localparam logic [TICK_W-1:0] TICK_LOAD = TICK_W'(TICK_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        REL_DB
    } btn_state_t;

    btn_state_t        state;
    logic              btn_meta;
    logic              btn_sync;
    logic [DB_W-1:0]   db_cnt;
    logic [DB_W-1:0]   db_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic              long_done;
    logic [TICK_W-1:0] tick_cnt;
    logic [1:0]        mode_q;
    logic              running_q;
    logic              press_q;
    logic              tick_q;
    logic              short_done;
    logic              long_fire;

    assign bus.mode        = mode_q;
    assign bus.running     = running_q;
    assign bus.press_pulse = press_q;
    assign bus.tick        = tick_q;

    // Two-flop synchroniser; resets to "released" so a held button after reset re-debounces.
    // NOTE: state registers use non-blocking (<=) assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            btn_meta <= 1'b1;
            btn_sync <= 1'b1;
        end else begin
            btn_meta <= bus.btn_n;
            btn_sync <= btn_meta;
        end
    end

    // Decode this cycle's short-press completion and long-press threshold crossing.
    // NOTE: every variable assigned here gets an unconditional value first, so no latch is inferred.
    always_comb begin
        db_next    = db_cnt + DB_W'(1);
        short_done = (state == REL_DB) && btn_sync && (db_next == DB_END) && !long_done;
        long_fire  = (state == HELD) && (hold_cnt == HOLD_END) && !long_done;
    end

    // Button FSM with registered mode / running / press_pulse outputs.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state     <= IDLE;
            db_cnt    <= '0;
            hold_cnt  <= '0;
            long_done <= 1'b0;
            mode_q    <= 2'd0;
            running_q <= 1'b1;
            press_q   <= 1'b0;
        end else begin
            press_q <= short_done;
            if (short_done) begin
                mode_q <= mode_q + 2'd1;
            end
            if (long_fire) begin
                running_q <= !running_q;
                long_done <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (!btn_sync) begin
                        state  <= PRESS_DB;
                        db_cnt <= '0;
                    end
                end
                PRESS_DB: begin
                    if (btn_sync) begin
                        state <= IDLE;
                    end else if (db_next == DB_END) begin
                        state     <= HELD;
                        hold_cnt  <= '0;
                        long_done <= 1'b0;
                    end else begin
                        db_cnt <= db_next;
                    end
                end
                HELD: begin
                    // Saturate so a very long hold neither wraps nor re-fires.
                    if (hold_cnt != HOLD_END) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                    if (btn_sync) begin
                        state  <= REL_DB;
                        db_cnt <= '0;
                    end
                end
                REL_DB: begin
                    // A bounce back low resumes the hold without losing long_done.
                    if (!btn_sync) begin
                        state <= HELD;
                    end else if (db_next == DB_END) begin
                        state <= IDLE;
                    end else begin
                        db_cnt <= db_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tick down-counter: restarts its period on a mode change or on resume, pulses at zero.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            tick_cnt <= TICK_LOAD;
            tick_q   <= 1'b0;
        end else if (short_done || (long_fire && !running_q)) begin
            tick_cnt <= TICK_LOAD;
            tick_q   <= 1'b0;
        end else if (running_q) begin
            if (tick_cnt == '0) begin
                tick_cnt <= TICK_LOAD;
                tick_q   <= 1'b1;
            end else begin
                tick_cnt <= tick_cnt - TICK_W'(1);
                tick_q   <= 1'b0;
            end
        end else begin
            tick_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed self-checking bench for led_mode_ctrl with small parameters
// (debounce 4, tick period 10, long press 20). Outputs are sampled on the
// falling clock edge; edge k means the k-th rising edge after reset release.
module tb_led_mode_ctrl;

    logic clk;
    logic nRst;
    int   n_checks;
    int   n_errors;
    int   tick_seen;
    int   press_seen;

    led_mode_ctrl_if bus ();

    led_mode_ctrl #(
        .DEBOUNCE_CYC(4),
        .TICK_CYC    (10),
        .LONG_CYC    (20)
    ) dut (
        .clk (clk),
        .nRst(nRst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running totals of pulses, sampled on the rising edge (pre-update values).
    always @(posedge clk) begin
        if (bus.tick)        tick_seen++;
        if (bus.press_pulse) press_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic short_press();
        bus.btn_n = 1'b0;
        cycles(8);
        bus.btn_n = 1'b1;
        cycles(10);
    endtask

    // Expect exactly one tick, on the 10th rising edge from now.
    task automatic check_tick_period(input string tag);
        for (int i = 1; i <= 10; i++) begin
            cycles(1);
            check($sformatf("%s_edge%0d", tag, i), bus.tick, (i == 10));
        end
    endtask

    initial begin
        int         p0;
        int         t0;
        bit         found;
        logic [1:0] exp_mode;

        n_checks   = 0;
        n_errors   = 0;
        tick_seen  = 0;
        press_seen = 0;
        nRst       = 1'b0;
        bus.btn_n  = 1'b1;

        // Reset state.
        cycles(3);
        check("reset_mode",    bus.mode, 2'd0);
        check("reset_running", bus.running, 1'b1);
        check("reset_tick",    bus.tick, 1'b0);
        check("reset_press",   bus.press_pulse, 1'b0);

        // Idle after reset: ticks exactly at edges 10, 20, 30.
        nRst = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            cycles(1);
            check($sformatf("idle_tick_edge%0d", k), bus.tick, (k % 10 == 0));
        end
        check("idle_mode",    bus.mode, 2'd0);
        check("idle_running", bus.running, 1'b1);

        // Clean short press: one press_pulse, mode 0->1, tick period restarts.
        p0 = press_seen;
        bus.btn_n = 1'b0;
        cycles(8);
        bus.btn_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycles(1);
            if (bus.press_pulse) found = 1'b1;
        end
        check("first_press_seen", found, 1'b1);
        check("tick_suppressed_on_mode_change", bus.tick, 1'b0);
        check("first_press_mode", bus.mode, 2'd1);
        check_tick_period("tick_after_mode_change");
        check("first_press_count", press_seen - p0, 1);

        // Bouncing button never completes a debounce.
        p0 = press_seen;
        repeat (5) begin
            bus.btn_n = 1'b0;
            cycles(2);
            bus.btn_n = 1'b1;
            cycles(2);
        end
        cycles(10);
        check("bounce_no_press", press_seen - p0, 0);
        check("bounce_mode", bus.mode, 2'd1);

        // Four short presses walk the mode through 2, 3, 0 (wrap), 1.
        p0 = press_seen;
        for (int k = 0; k < 4; k++) begin
            short_press();
            exp_mode = 2'(k + 2);
            check($sformatf("press_seq_mode%0d", k), bus.mode, exp_mode);
        end
        check("press_seq_count", press_seen - p0, 4);

        // Long press pauses; release does not step the mode; no ticks while paused.
        p0 = press_seen;
        bus.btn_n = 1'b0;
        cycles(40);
        check("long_press_paused", bus.running, 1'b0);
        bus.btn_n = 1'b1;
        cycles(10);
        check("long_release_mode", bus.mode, 2'd1);
        check("long_release_no_press", press_seen - p0, 0);
        t0 = tick_seen;
        cycles(30);
        check("paused_no_ticks", tick_seen - t0, 0);
        check("paused_tick_low", bus.tick, 1'b0);
        check("paused_still", bus.running, 1'b0);

        // Second long press resumes; first tick 10 edges after running rises.
        bus.btn_n = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycles(1);
            if (bus.running) found = 1'b1;
        end
        check("resume_seen", found, 1'b1);
        check_tick_period("tick_after_resume");
        bus.btn_n = 1'b1;
        cycles(10);
        check("resume_release_mode", bus.mode, 2'd1);
        check("resume_release_no_press", press_seen - p0, 0);
        check("resume_running", bus.running, 1'b1);

        // Reset while held with mode=2: press discarded, defaults restored at once.
        short_press();
        check("pre_reset_mode", bus.mode, 2'd2);
        bus.btn_n = 1'b0;
        cycles(10);
        nRst = 1'b0;
        #1;
        check("midpress_reset_mode",    bus.mode, 2'd0);
        check("midpress_reset_running", bus.running, 1'b1);
        check("midpress_reset_press",   bus.press_pulse, 1'b0);
        check("midpress_reset_tick",    bus.tick, 1'b0);
        bus.btn_n = 1'b1;
        cycles(3);
        p0 = press_seen;
        nRst = 1'b1;
        check_tick_period("tick_after_reset");
        check("post_reset_no_press", press_seen - p0, 0);
        check("post_reset_mode", bus.mode, 2'd0);

        // Button still low across reset release restarts debounce from IDLE,
        // so releasing it before a full debounce yields no press.
        bus.btn_n = 1'b0;
        cycles(10);
        nRst = 1'b0;
        cycles(2);
        p0 = press_seen;
        nRst = 1'b1;
        cycles(3);
        bus.btn_n = 1'b1;
        cycles(12);
        check("held_through_reset_no_press", press_seen - p0, 0);
        check("held_through_reset_mode", bus.mode, 2'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
